button_conditioner: RTL and testbench

Converts raw, asynchronous, bouncing pushbutton inputs into clean, clock-synchronous signals for use inside the icebreaker designs. Each button bit passes through a multi-flop synchronizer and a per-bit debounce counter. The block then produces a debounced level plus single-cycle press and release pulses. It sits between the board-level `button_async_unsafe_i` pins and any logic that consumes button state (gates, counters, LED drivers).

---
 rtl/button_conditioner.sv | 78 +++++++
 tb/tb_button_conditioner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Synchronizes and debounces raw pushbuttons; emits level and
//            single-cycle press/release pulses per bit.
// Revision : 1.0
// ============================================================================
module button_conditioner #(
  parameter int width_p           = 3,
  parameter int sync_stages_p     = 2,
  parameter int debounce_cycles_p = 120000
) (
  input  logic               clk_i,
  input  logic               reset_n_async_i,
  input  logic [width_p-1:0] button_async_unsafe_i,
  output logic [width_p-1:0] level_o,
  output logic [width_p-1:0] press_o,
  output logic [width_p-1:0] release_o
);

  localparam int                   c_cnt_w    = $clog2(debounce_cycles_p + 1);
  localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(debounce_cycles_p - 1);
  localparam logic [c_cnt_w-1:0]   c_cnt_one  = c_cnt_w'(1);

  for (genvar gi = 0; gi < width_p; gi++) begin : g_bit
    logic [sync_stages_p-1:0] r_sync;
    logic [c_cnt_w-1:0]       r_count;
    logic                     r_level;
    logic                     r_press;
    logic                     r_release;
    logic                     w_sync;
    logic                     w_mismatch;
    logic                     w_expire;

    assign w_sync     = r_sync[sync_stages_p-1];
    assign w_mismatch = (w_sync != r_level);
    // The count reaching its last value on a mismatch is the debounce decision.
    assign w_expire   = w_mismatch && (r_count == c_cnt_last);

    always_ff @(posedge clk_i or negedge reset_n_async_i) begin
      if (!reset_n_async_i) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[sync_stages_p-2:0], button_async_unsafe_i[gi]};
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_async_i) begin
      if (!reset_n_async_i) begin
        r_count <= '0;
      end else if (!w_mismatch || w_expire) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + c_cnt_one;
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_async_i) begin
      if (!reset_n_async_i) begin
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_expire && !r_level;
        r_release <= w_expire && r_level;
        if (w_expire) begin
          r_level <= !r_level;
        end
      end
    end

    assign level_o[gi]   = r_level;
    assign press_o[gi]   = r_press;
    assign release_o[gi] = r_release;
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Directed-vector bench with a sliding-window debounce model.
// Revision : 1.0
// ============================================================================
module tb_button_conditioner;
  localparam int W    = 3;
  localparam int SY   = 2;
  localparam int D    = 4;
  localparam int MAXE = 4096;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] btn;
  logic [W-1:0] level, press, rel;

  int n_cmp = 0;
  int n_err = 0;

  button_conditioner #(
    .width_p(W), .sync_stages_p(SY), .debounce_cycles_p(D)
  ) dut (
    .clk_i(clk),
    .reset_n_async_i(rst_n),
    .button_async_unsafe_i(btn),
    .level_o(level),
    .press_o(press),
    .release_o(rel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model: input history per edge since reset; a bit toggles when the
  // synchronized value seen on each of the last D edges differs from the
  // current level and no toggle happened inside that window.
  logic [W-1:0] xh [0:MAXE];
  int           en;
  int           last_t [W];
  logic [W-1:0] m_level, m_press, m_release;
  bit           m_valid = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en        = 0;
      m_level   = '0;
      m_press   = '0;
      m_release = '0;
      for (int i = 0; i < W; i++) last_t[i] = 0;
      m_valid   = 1;
    end else begin
      en++;
      if (en <= MAXE) xh[en] = btn;
      m_press   = '0;
      m_release = '0;
      for (int i = 0; i < W; i++) begin
        bit ok;
        ok = (en <= MAXE) && (en - D >= last_t[i]);
        for (int j = 0; j < D; j++) begin
          int   e;
          logic s;
          e = en - j;
          s = (ok && e - SY >= 1) ? xh[e - SY][i] : 1'b0;
          if (s == m_level[i]) ok = 0;
        end
        if (ok) begin
          if (m_level[i]) m_release[i] = 1'b1;
          else            m_press[i]   = 1'b1;
          m_level[i] = ~m_level[i];
          last_t[i]  = en;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_level", level, m_level);
      chk("model_press", press, m_press);
      chk("model_release", rel, m_release);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_level"}, level, '0);
    chk({name, "_press"}, press, '0);
    chk({name, "_release"}, rel, '0);
  endtask

  // Extra mixed-bounce vectors, one per cycle.
  logic [W-1:0] vec [0:23] = '{
    3'b001, 3'b011, 3'b010, 3'b111, 3'b111, 3'b111, 3'b110, 3'b111,
    3'b111, 3'b111, 3'b111, 3'b101, 3'b100, 3'b000, 3'b000, 3'b010,
    3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 3'b011, 3'b011, 3'b011
  };

  initial begin
    rst_n = 1'b1;
    btn   = 3'b111;
    #1 rst_n = 1'b0;
    #1 chk_zero("reset_immediate");
    cyc(3);
    chk_zero("reset_held");

    // Button held through reset: press after full latency from deassertion.
    rst_n = 1'b1;
    cyc(5);
    chk("held_early_level", level, 3'b000);
    cyc(1);
    chk("held_press", press, 3'b111);
    chk("held_level", level, 3'b111);
    cyc(1);
    chk("held_press_end", press, 3'b000);

    // Asynchronous reset asserted mid-cycle while levels are high.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midcycle_reset");
    btn = 3'b000;
    cyc(2);
    rst_n = 1'b1;
    cyc(8);

    // Clean press on bit0.
    btn = 3'b001;
    cyc(5);
    chk("press_early", level, 3'b000);
    cyc(1);
    chk("press_level", level, 3'b001);
    chk("press_pulse", press, 3'b001);
    cyc(1);
    chk("press_pulse_end", press, 3'b000);
    cyc(3);

    // Release of bit0.
    btn = 3'b000;
    cyc(5);
    chk("release_early", level, 3'b001);
    cyc(1);
    chk("release_level", level, 3'b000);
    chk("release_pulse", rel, 3'b001);
    cyc(1);
    chk("release_pulse_end", rel, 3'b000);
    cyc(3);

    // Bounce on bit1: three high cycles then low, five times.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        btn = (k < 3) ? 3'b010 : 3'b000;
        cyc(1);
        chk("bounce_level", level, 3'b000);
        chk("bounce_press", press, 3'b000);
      end
    end
    btn = 3'b010;
    cyc(4);
    btn = 3'b000;
    cyc(1);
    chk("bounce_hold_early", level, 3'b000);
    cyc(1);
    chk("bounce_hold_press", press, 3'b010);
    cyc(10);
    chk("bounce_settled", level, 3'b000);

    // Simultaneous bits 0 and 2.
    btn = 3'b101;
    cyc(5);
    chk("simul_early", press, 3'b000);
    cyc(1);
    chk("simul_press", press, 3'b101);
    chk("simul_level", level, 3'b101);
    cyc(1);
    chk("simul_press_end", press, 3'b000);
    btn = 3'b000;
    cyc(10);

    // Reset mid-count on bit2, after edge 5.
    btn = 3'b100;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midcount_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(5);
    chk("midcount_early", press, 3'b000);
    cyc(1);
    chk("midcount_press", press, 3'b100);
    btn = 3'b000;
    cyc(10);

    // Mixed bounce table, checked by the model.
    for (int v = 0; v < 24; v++) begin
      btn = vec[v];
      cyc(1);
    end
    btn = 3'b000;
    cyc(12);
    chk("final_level", level, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
